sdio_data_tx: RTL

// - SDIO device-side data transmitter for read transfers (card -> host), SD4 SDR mode, 4 data lines.
// - Pulls bytes from the function/CIA data source, serialises them nibble-wise onto DAT[3:0].
// - Frames each block: start bit, payload, per-line CRC16, end bit. Owns the bus direction.
// - Sits beside the write-path data PHY. Command layer drives i_activate/i_data_count.

---
 rtl/sdio_data_tx_pkg.sv | 23 ++
 rtl/sdio_data_tx_crc16.sv | 19 +
 rtl/sdio_data_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sdio_data_tx_pkg.sv
// Shared constants for the SDIO SD4 read-data transmitter: FSM encodings,
// CRC parameters, DAT idle level and the serial CRC16 step.
package sdio_data_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CRC   = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam int          CRC_LEN           = 16;
  localparam int          BLOCK_MAX_DEFAULT = 512;
  localparam logic [15:0] CRC_POLY          = 16'h1021;
  localparam logic [3:0]  DAT_IDLE          = 4'hF;

  // One serial step of x^16+x^12+x^5+1, feedback taken from the MSB.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdio_data_tx_crc16.sv
// Serial CRC16 for one DAT line; cleared by rst, advances one bit when en is high.
module sdio_data_tx_crc16
  import sdio_data_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst)
      crc <= 16'h0000;
    else if (en)
      crc <= crc16_step(crc, din);
  end

endmodule

// File: rtl/sdio_data_tx.sv
// SDIO device-side read-data transmitter, SD4 SDR: start bit, nibble-wise
// payload, per-line CRC16 and end bit, with bus-direction ownership.
module sdio_data_tx
  import sdio_data_tx_pkg::*;
#(
  parameter int CRC_BITS  = CRC_LEN,
  parameter int BLOCK_MAX = BLOCK_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_activate,
  input  logic [9:0] i_data_count,
  input  logic       i_host_rdy,
  input  logic       i_rd_valid,
  input  logic [7:0] i_rd_data,
  output logic       o_rd_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_underrun,
  output logic       o_sdio_data_dir,
  output logic [3:0] o_sdio_data_out
);

  logic [2:0]       state;
  logic [9:0]       n_bytes;
  logic [9:0]       byte_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       next_byte;
  logic             low_phase;
  logic             have_byte;
  logic [3:0]       crc_cnt;
  logic             underrun;
  logic [3:0][15:0] crc_q;
  logic [3:0]       data_nib;
  logic [3:0]       crc_nib;
  logic [3:0]       crc_bit_idx;
  logic             last_byte;
  logic             take;
  logic             starve;
  logic             crc_rst;
  logic             crc_en;

  assign last_byte   = (byte_idx == n_bytes - 10'd1);
  assign data_nib    = low_phase ? shift_reg[3:0] : shift_reg[7:4];
  assign crc_bit_idx = 4'(CRC_BITS - 1) - crc_cnt;
  assign take        = i_rd_valid && o_rd_ready;
  assign starve      = (state == ST_DATA) && !low_phase && !last_byte && !i_rd_valid;
  assign crc_rst     = rst || (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_START);
  assign crc_en      = (state == ST_DATA);
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);
  assign o_underrun  = underrun;

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sdio_data_tx_crc16 u_crc (
      .clk (clk),
      .rst (crc_rst),
      .en  (crc_en),
      .din (data_nib[i]),
      .crc (crc_q[i])
    );
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      crc_nib[i] = crc_q[i][crc_bit_idx];
  end

  // Only one handshake slot per byte: the high-nibble cycle, so a late source starves.
  always_comb begin
    o_rd_ready = 1'b0;
    if (state == ST_FETCH)
      o_rd_ready = !have_byte;
    else if (state == ST_DATA)
      o_rd_ready = !low_phase && !last_byte;
  end

  always_comb begin
    o_sdio_data_dir = 1'b0;
    o_sdio_data_out = DAT_IDLE;
    case (state)
      ST_START: begin o_sdio_data_dir = 1'b1; o_sdio_data_out = 4'h0;     end
      ST_DATA:  begin o_sdio_data_dir = 1'b1; o_sdio_data_out = data_nib; end
      ST_CRC:   begin o_sdio_data_dir = 1'b1; o_sdio_data_out = crc_nib;  end
      ST_END:   begin o_sdio_data_dir = 1'b1;                             end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      n_bytes   <= 10'd0;
      byte_idx  <= 10'd0;
      shift_reg <= 8'h00;
      next_byte <= 8'h00;
      low_phase <= 1'b0;
      have_byte <= 1'b0;
      crc_cnt   <= 4'd0;
      underrun  <= 1'b0;
    end else begin
      if (starve)
        underrun <= 1'b1;
      // Dropping i_activate releases the bus from any state, even mid-byte.
      if (state != ST_IDLE && !i_activate) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (i_activate) begin
            n_bytes   <= (i_data_count == 10'd0) ? 10'(BLOCK_MAX) : i_data_count;
            underrun  <= 1'b0;
            have_byte <= 1'b0;
            state     <= ST_FETCH;
          end
          ST_FETCH: begin
            if (take) begin
              shift_reg <= i_rd_data;
              have_byte <= 1'b1;
            end else if (have_byte && i_host_rdy) begin
              state <= ST_START;
            end
          end
          ST_START: begin
            low_phase <= 1'b0;
            byte_idx  <= 10'd0;
            state     <= ST_DATA;
          end
          ST_DATA: begin
            if (!low_phase) begin
              next_byte <= take ? i_rd_data : 8'h00;
              low_phase <= 1'b1;
            end else begin
              low_phase <= 1'b0;
              shift_reg <= next_byte;
              if (last_byte) begin
                crc_cnt <= 4'd0;
                state   <= ST_CRC;
              end else begin
                byte_idx <= byte_idx + 10'd1;
              end
            end
          end
          ST_CRC: begin
            if (crc_cnt == 4'(CRC_BITS - 1))
              state <= ST_END;
            else
              crc_cnt <= crc_cnt + 4'd1;
          end
          ST_END:  state <= ST_DONE;
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
